alu_wb_buf: RTL and testbench

//  Writeback stage directly downstream of the ALU. Accepts one ALU result per cycle: res, fo, wb_en, flag_en, dest reg.

---
 rtl/alu_wb_buf.sv | 187 ++++++++++++++++++
 tb/tb_alu_wb_buf.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_wb_buf.sv
// -----------------------------------------------------------------------------
// alu_wb_buf
//
// Writeback stage that sits directly behind the ALU. Each cycle it can take one
// ALU result. It keeps the architectural flag register that feeds the ALU fi
// input. It parks up to two register-file writes while the register-file write
// port is stalled. It also answers one combinational forwarding lookup against
// the results that are buffered but not yet written.
//
// Parameters
//   WIDTH     datapath width of results / register data
//   RA_W      register index width
//   FLAG_RST  flag register value after reset
//
// Ports
//   clk_i          clock, all state changes on the rising edge
//   rst_ni         asynchronous active-low reset
//   in_valid_i     ALU result valid this cycle
//   in_ready_o     stage can accept a result (buffer not full)
//   in_res_i       ALU result data
//   in_fo_i        ALU output flags
//   in_wb_en_i     result must be written to in_rd_i
//   in_flag_en_i   in_fo_i must be loaded into the flag register
//   in_rd_i        destination register index
//   flags_o        flag register (to ALU fi)
//   fl_we_i        external flag write (SFR path)
//   fl_wd_i        external flag write data
//   rf_we_o        register-file write request (head entry valid)
//   rf_wa_o        register-file write address (head entry)
//   rf_wd_o        register-file write data (head entry)
//   rf_ack_i       register file takes the write this cycle
//   lk_ra_i        forwarding lookup index
//   lk_hit_o       lk_ra_i matches a buffered entry
//   lk_data_o      data of the youngest matching entry
//   flush_i        synchronous discard of all buffered writes
// -----------------------------------------------------------------------------
module alu_wb_buf #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned RA_W     = 4,
  parameter logic [7:0]  FLAG_RST = 8'h00
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_res_i,
  input  logic [7:0]       in_fo_i,
  input  logic             in_wb_en_i,
  input  logic             in_flag_en_i,
  input  logic [RA_W-1:0]  in_rd_i,
  output logic [7:0]       flags_o,
  input  logic             fl_we_i,
  input  logic [7:0]       fl_wd_i,
  output logic             rf_we_o,
  output logic [RA_W-1:0]  rf_wa_o,
  output logic [WIDTH-1:0] rf_wd_o,
  input  logic             rf_ack_i,
  input  logic [RA_W-1:0]  lk_ra_i,
  output logic             lk_hit_o,
  output logic [WIDTH-1:0] lk_data_o,
  input  logic             flush_i
);

  // The buffer occupancy doubles as the stage's state machine.
  typedef enum logic [1:0] {
    FILL_EMPTY = 2'd0,
    FILL_ONE   = 2'd1,
    FILL_FULL  = 2'd2
  } fill_e;

  fill_e            fill_q, fill_d;
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [7:0]       flags_q, flags_d;
  logic [WIDTH-1:0] data_q [2];
  logic [RA_W-1:0]  addr_q [2];

  logic accept;
  logic push;
  logic pop;
  logic youngIdx;

  // Handshake and head-of-buffer outputs. These depend only on registered
  // state, so rf_ack_i never feeds back into in_ready_o.
  assign in_ready_o = (fill_q != FILL_FULL);
  assign rf_we_o    = (fill_q != FILL_EMPTY);
  assign rf_wa_o    = rf_we_o ? addr_q[head_q] : '0;
  assign rf_wd_o    = rf_we_o ? data_q[head_q] : '0;
  assign flags_o    = flags_q;

  // A flush suppresses both the buffer write and the buffer read of its
  // cycle. A result that is not written back (cmp/test) is never stored.
  assign accept   = in_valid_i & in_ready_o;
  assign push     = accept & in_wb_en_i & ~flush_i;
  assign pop      = rf_we_o & rf_ack_i & ~flush_i;
  assign youngIdx = ~tail_q;

  // Occupancy next-state logic. A push into a full buffer cannot happen
  // because in_ready_o is low. A pop from an empty buffer cannot happen
  // because rf_we_o is low.
  always_comb begin
    fill_d = fill_q;
    if (flush_i) begin
      fill_d = FILL_EMPTY;
    end else begin
      unique case (fill_q)
        FILL_EMPTY: if (push) fill_d = FILL_ONE;
        FILL_ONE: begin
          if (push && !pop)      fill_d = FILL_FULL;
          else if (!push && pop) fill_d = FILL_EMPTY;
        end
        FILL_FULL:  if (pop) fill_d = FILL_ONE;
        default:    fill_d = FILL_EMPTY;
      endcase
    end
  end

  // Pointer next-state logic. A flush collapses the buffer by moving head
  // onto tail, which keeps the invariant tail = head + count.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (flush_i) begin
      head_d = tail_q;
    end else begin
      if (pop)  head_d = ~head_q;
      if (push) tail_d = ~tail_q;
    end
  end

  // Flag register update. A flag load from an accepted ALU result takes
  // priority over the SFR write path. It happens even if a flush occurs in
  // the same cycle and even if the result is not buffered.
  always_comb begin
    flags_d = flags_q;
    if (accept && in_flag_en_i) begin
      flags_d = in_fo_i;
    end else if (fl_we_i) begin
      flags_d = fl_wd_i;
    end
  end

  // Forwarding lookup. The youngest entry sits just behind tail and is
  // checked first. The older entry is only valid when the buffer is full.
  // With one entry, head and the youngest slot are the same.
  always_comb begin
    lk_hit_o  = 1'b0;
    lk_data_o = '0;
    if ((fill_q != FILL_EMPTY) && (addr_q[youngIdx] == lk_ra_i)) begin
      lk_hit_o  = 1'b1;
      lk_data_o = data_q[youngIdx];
    end else if ((fill_q == FILL_FULL) && (addr_q[head_q] == lk_ra_i)) begin
      lk_hit_o  = 1'b1;
      lk_data_o = data_q[head_q];
    end
  end

  // Control state register. Reset drops every buffered write at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fill_q  <= FILL_EMPTY;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      flags_q <= FLAG_RST;
    end else begin
      fill_q  <= fill_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      flags_q <= flags_d;
    end
  end

  // Entry storage. An entry is written only when a result is pushed into
  // the tail slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else if (push) begin
      data_q[tail_q] <= in_res_i;
      addr_q[tail_q] <= in_rd_i;
    end
  end

endmodule

// File: tb/tb_alu_wb_buf.sv
// -----------------------------------------------------------------------------
// tb_alu_wb_buf
//
// Self-checking bench for alu_wb_buf. A queue of pending register writes plus
// a flag byte serves as the reference. Each cycle it is stepped from the
// stimulus that was driven. DUT outputs are compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_wb_buf;

  logic        clk;
  logic        rstN;
  logic        inValid;
  logic        inReady;
  logic [31:0] inRes;
  logic [7:0]  inFo;
  logic        inWbEn;
  logic        inFlagEn;
  logic [3:0]  inRd;
  logic [7:0]  flagsO;
  logic        flWe;
  logic [7:0]  flWd;
  logic        rfWe;
  logic [3:0]  rfWa;
  logic [31:0] rfWd;
  logic        rfAck;
  logic [3:0]  lkRa;
  logic        lkHit;
  logic [31:0] lkData;
  logic        flush;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [3:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t     modelQ[$];
  logic [7:0] modelFlags = 8'h00;

  alu_wb_buf #(
    .WIDTH    (32),
    .RA_W     (4),
    .FLAG_RST (8'h00)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .in_valid_i   (inValid),
    .in_ready_o   (inReady),
    .in_res_i     (inRes),
    .in_fo_i      (inFo),
    .in_wb_en_i   (inWbEn),
    .in_flag_en_i (inFlagEn),
    .in_rd_i      (inRd),
    .flags_o      (flagsO),
    .fl_we_i      (flWe),
    .fl_wd_i      (flWd),
    .rf_we_o      (rfWe),
    .rf_wa_o      (rfWa),
    .rf_wd_o      (rfWd),
    .rf_ack_i     (rfAck),
    .lk_ra_i      (lkRa),
    .lk_hit_o     (lkHit),
    .lk_data_o    (lkData),
    .flush_i      (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] res, input logic [7:0] fo,
                               input logic wb, input logic fe, input logic [3:0] rd,
                               input logic fw, input logic [7:0] fwd, input logic ack,
                               input logic [3:0] lk, input logic fl);
    inValid  = v;
    inRes    = res;
    inFo     = fo;
    inWbEn   = wb;
    inFlagEn = fe;
    inRd     = rd;
    flWe     = fw;
    flWd     = fwd;
    rfAck    = ack;
    lkRa     = lk;
    flush    = fl;
  endtask

  task automatic applyRandom(input int flushOneIn);
    applyStimulus(($urandom_range(3) != 0), $urandom, 8'($urandom), 1'($urandom),
                  1'($urandom), 4'($urandom_range(3)), ($urandom_range(3) == 0), 8'($urandom),
                  1'($urandom), 4'($urandom_range(3)), ($urandom_range(flushOneIn - 1) == 0));
  endtask

  // Expected outputs come straight from the pending-write queue: the oldest
  // write is presented to the register file, and the newest match forwards.
  task automatic checkOutput(input string tag);
    logic        expHit;
    logic [31:0] expData;
    expHit  = 1'b0;
    expData = 32'h0;
    for (int i = modelQ.size() - 1; i >= 0; i--) begin
      if (!expHit && modelQ[i].rd == lkRa) begin
        expHit  = 1'b1;
        expData = modelQ[i].data;
      end
    end
    checkEq({tag, "_flags"},   32'(flagsO),  32'(modelFlags));
    checkEq({tag, "_inReady"}, 32'(inReady), 32'(modelQ.size() != 2));
    checkEq({tag, "_rfWe"},    32'(rfWe),    32'(modelQ.size() != 0));
    checkEq({tag, "_rfWa"},    32'(rfWa),    (modelQ.size() != 0) ? 32'(modelQ[0].rd) : 32'h0);
    checkEq({tag, "_rfWd"},    rfWd,         (modelQ.size() != 0) ? modelQ[0].data : 32'h0);
    checkEq({tag, "_lkHit"},   32'(lkHit),   32'(expHit));
    checkEq({tag, "_lkData"},  lkData,       expData);
  endtask

  // Advance one rising edge and step the reference with the stimulus that
  // the DUT has just sampled.
  task automatic tick();
    logic acc;
    logic doPop;
    @(posedge clk);
    if (!rstN) begin
      modelQ.delete();
      modelFlags = 8'h00;
    end else begin
      acc   = inValid && (modelQ.size() < 2);
      doPop = (modelQ.size() > 0) && rfAck;
      if (acc && inFlagEn) modelFlags = inFo;
      else if (flWe)       modelFlags = flWd;
      if (flush) begin
        modelQ.delete();
      end else begin
        if (doPop) void'(modelQ.pop_front());
        if (acc && inWbEn) modelQ.push_back('{rd: inRd, data: inRes});
      end
    end
    #1;
  endtask

  task automatic cycle(input string tag);
    @(negedge clk);
    checkOutput(tag);
    tick();
  endtask

  initial begin
    rstN = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] reset held with random inputs");
    for (int i = 0; i < 4; i++) begin
      applyRandom(4);
      @(negedge clk);
      checkEq("rst_flags", 32'(flagsO), 32'h00);
      checkEq("rst_rfWe", 32'(rfWe), 32'h0);
      checkEq("rst_inReady", 32'(inReady), 32'h1);
      checkEq("rst_lkHit", 32'(lkHit), 32'h0);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 rstN = 1'b1;
    cycle("rel");

    $display("[TB] single accept");
    applyStimulus(1, 32'h12345678, 8'h05, 1, 1, 4'd3, 0, 0, 1, 0, 0);
    cycle("t2a");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    checkOutput("t2b");
    checkEq("t2_rfWe", 32'(rfWe), 32'h1);
    checkEq("t2_rfWa", 32'(rfWa), 32'h3);
    checkEq("t2_rfWd", rfWd, 32'h12345678);
    checkEq("t2_flags", 32'(flagsO), 32'h05);
    tick();
    @(negedge clk);
    checkEq("t2_rfWeLow", 32'(rfWe), 32'h0);
    tick();

    $display("[TB] stalled register file");
    applyStimulus(1, 32'h111, 0, 1, 0, 4'd1, 0, 0, 0, 0, 0);
    cycle("t3a");
    applyStimulus(1, 32'h222, 0, 1, 0, 4'd2, 0, 0, 0, 0, 0);
    cycle("t3b");
    applyStimulus(1, 32'h333, 0, 1, 0, 4'd3, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t3c");
    checkEq("t3_readyLow", 32'(inReady), 32'h0);
    tick();
    applyStimulus(1, 32'h333, 0, 1, 0, 4'd3, 0, 0, 1, 0, 0);
    @(negedge clk);
    checkOutput("t3d");
    checkEq("t3_wr1", 32'(rfWa), 32'h1);
    tick();
    @(negedge clk);
    checkOutput("t3e");
    checkEq("t3_wr2", 32'(rfWa), 32'h2);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    checkOutput("t3f");
    checkEq("t3_wr3", 32'(rfWa), 32'h3);
    checkEq("t3_wd3", rfWd, 32'h333);
    tick();
    cycle("t3g");

    $display("[TB] forwarding");
    applyStimulus(1, 32'hA, 0, 1, 0, 4'd5, 0, 0, 0, 0, 0);
    cycle("t4a");
    applyStimulus(1, 32'hB, 0, 1, 0, 4'd5, 0, 0, 0, 0, 0);
    cycle("t4b");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd5, 0);
    @(negedge clk);
    checkOutput("t4c");
    checkEq("t4_hit5", 32'(lkHit), 32'h1);
    checkEq("t4_data5", lkData, 32'hB);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd6, 0);
    @(negedge clk);
    checkOutput("t4d");
    checkEq("t4_hit6", 32'(lkHit), 32'h0);
    checkEq("t4_data6", lkData, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd5, 0);
    cycle("t4e");
    cycle("t4f");

    $display("[TB] flag priority");
    applyStimulus(1, 32'hDEAD, 8'h02, 0, 1, 4'd4, 1, 8'h80, 0, 4'd4, 0);
    cycle("t5a");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 8'h80, 0, 4'd4, 0);
    @(negedge clk);
    checkOutput("t5b");
    checkEq("t5_aluWins", 32'(flagsO), 32'h02);
    checkEq("t5_noStore", 32'(rfWe), 32'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t5c");
    checkEq("t5_sfr", 32'(flagsO), 32'h80);
    tick();

    $display("[TB] flush");
    applyStimulus(1, 32'h70, 0, 1, 0, 4'd7, 0, 0, 0, 0, 0);
    cycle("t6a");
    cycle("t6b");
    applyStimulus(1, 32'h90, 8'h44, 1, 1, 4'd9, 0, 0, 1, 4'd7, 1);
    cycle("t6c");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd7, 0);
    @(negedge clk);
    checkOutput("t6d");
    checkEq("t6_rfWe", 32'(rfWe), 32'h0);
    checkEq("t6_ready", 32'(inReady), 32'h1);
    checkEq("t6_lkHit", 32'(lkHit), 32'h0);
    tick();
    applyStimulus(1, 32'h71, 0, 1, 0, 4'd7, 0, 0, 0, 0, 0);
    cycle("t6e");
    applyStimulus(1, 32'h91, 8'h33, 1, 1, 4'd9, 0, 0, 1, 4'd9, 1);
    cycle("t6f");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd9, 0);
    @(negedge clk);
    checkOutput("t6g");
    checkEq("t6_pushDropped", 32'(rfWe), 32'h0);
    checkEq("t6_flagsKept", 32'(flagsO), 32'h33);
    tick();

    $display("[TB] asynchronous reset mid-stream");
    applyStimulus(1, 32'h55, 8'h66, 1, 1, 4'd2, 0, 0, 0, 4'd2, 0);
    cycle("t7a");
    cycle("t7b");
    #2 rstN = 1'b0;
    #1;
    checkEq("t7_rfWe", 32'(rfWe), 32'h0);
    checkEq("t7_ready", 32'(inReady), 32'h1);
    checkEq("t7_flags", 32'(flagsO), 32'h00);
    checkEq("t7_lkHit", 32'(lkHit), 32'h0);
    checkEq("t7_rfWa", 32'(rfWa), 32'h0);
    tick();
    #2 rstN = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("t7c");

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyRandom(16);
      cycle("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
